// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
// Parity helper covers entries up to PAR_MAX_W bits wide.
package regfile_pkg;

    localparam int PAR_MAX_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        even_parity = ^d;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port with write-to-read bypass.
// Parity error output present only when REGFILE_PARITY_EN is defined.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              rd_accept,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef REGFILE_PARITY_EN
    input  logic              mem_perr,
    output logic              rd_perr,
`endif
    input  logic              wr_accept,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic              hit_s;
    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;
`ifdef REGFILE_PARITY_EN
    logic              perr_d, perr_q;
`endif

    // Next read data: bypass the in-flight write, otherwise hold on idle cycles.
    always_comb begin
        hit_s   = wr_accept && (wr_addr == rd_addr);
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef REGFILE_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (rd_accept) begin
            valid_d = 1'b1;
            if (hit_s) begin
                data_d = wr_data;
            end else begin
                data_d = mem_rdata;
`ifdef REGFILE_PARITY_EN
                perr_d = mem_perr;
`endif
            end
        end else begin
            data_d  = data_q;
            valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            data_q  <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
`ifdef REGFILE_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef REGFILE_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
`ifdef REGFILE_PARITY_EN
    assign rd_perr  = perr_q;
`endif

endmodule

// File: rtl/regfile_param.sv
// DEPTH x DATA_W register file: one write port, two registered read ports, fill sequencer.
// Optional per-entry even parity with REGFILE_PARITY_EN.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b,
`ifdef REGFILE_PARITY_EN
    output logic              rd_perr_a,
    output logic              rd_perr_b,
    input  logic              par_flip,
`endif
    input  logic              fill_req,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy
);

    fill_state_e       state_d, state_q;
    logic [ADDR_W:0]   cnt_d, cnt_q;
    logic [DATA_W-1:0] pattern_d, pattern_q;
    logic              busy_d, busy_q;
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic fill_start_s;
    logic wr_accept_s;
    logic rd_accept_a_s;
    logic rd_accept_b_s;

`ifdef REGFILE_PARITY_EN
    logic par_d [DEPTH];
    logic par_q [DEPTH];
    logic perr_a_s;
    logic perr_b_s;
`endif

    // Port acceptance; a fill starting this cycle takes priority over the write.
    always_comb begin
        fill_start_s  = (state_q == IDLE) && fill_req;
        wr_accept_s   = enable && wr_en && !busy_q && !fill_start_s;
        rd_accept_a_s = enable && rd_en_a && !busy_q;
        rd_accept_b_s = enable && rd_en_b && !busy_q;
    end

    // Fill sequencer next state; runs regardless of enable.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (fill_req) begin
                    state_d   = FILL;
                    cnt_d     = {(ADDR_W+1){1'b0}};
                    pattern_d = fill_data;
                    busy_d    = 1'b1;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            FILL: begin
                if (cnt_q == (ADDR_W+1)'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = {(ADDR_W+1){1'b0}};
                    busy_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {(ADDR_W+1){1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // Storage next state: fill sweep entry, else the accepted write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
`ifdef REGFILE_PARITY_EN
            par_d[i] = par_q[i];
`endif
            if ((state_q == FILL) && (cnt_q[ADDR_W-1:0] == ADDR_W'(i))) begin
                mem_d[i] = pattern_q;
`ifdef REGFILE_PARITY_EN
                par_d[i] = even_parity(PAR_MAX_W'(pattern_q));
`endif
            end else if (wr_accept_s && (wr_addr == ADDR_W'(i))) begin
                mem_d[i] = wr_data;
`ifdef REGFILE_PARITY_EN
                par_d[i] = even_parity(PAR_MAX_W'(wr_data)) ^ par_flip;
`endif
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            cnt_q     <= {(ADDR_W+1){1'b0}};
            pattern_q <= {DATA_W{1'b0}};
            busy_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
`ifdef REGFILE_PARITY_EN
                par_q[i] <= 1'b0;
`endif
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            busy_q    <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
`ifdef REGFILE_PARITY_EN
                par_q[i] <= par_d[i];
`endif
            end
        end
    end

`ifdef REGFILE_PARITY_EN
    // Stored parity check on the raw array words feeding each port.
    always_comb begin
        perr_a_s = even_parity(PAR_MAX_W'(mem_q[rd_addr_a])) != par_q[rd_addr_a];
        perr_b_s = even_parity(PAR_MAX_W'(mem_q[rd_addr_b])) != par_q[rd_addr_b];
    end
`endif

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_a (
        .clk       (clk),
        .clear     (clear),
        .rd_accept (rd_accept_a_s),
        .rd_addr   (rd_addr_a),
        .mem_rdata (mem_q[rd_addr_a]),
`ifdef REGFILE_PARITY_EN
        .mem_perr  (perr_a_s),
        .rd_perr   (rd_perr_a),
`endif
        .wr_accept (wr_accept_s),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data_a),
        .rd_valid  (rd_valid_a)
    );

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_b (
        .clk       (clk),
        .clear     (clear),
        .rd_accept (rd_accept_b_s),
        .rd_addr   (rd_addr_b),
        .mem_rdata (mem_q[rd_addr_b]),
`ifdef REGFILE_PARITY_EN
        .mem_perr  (perr_b_s),
        .rd_perr   (rd_perr_b),
`endif
        .wr_accept (wr_accept_s),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data_b),
        .rd_valid  (rd_valid_b)
    );

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed cases plus randomized traffic against a behavioural model.
module tb_regfile_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              clear;
    logic              enable;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en_a, rd_en_b;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;
    logic              rd_valid_a, rd_valid_b;
    logic              rd_perr_a, rd_perr_b;
    logic              par_flip;
    logic              fill_req;
    logic [DATA_W-1:0] fill_data;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_bad [DEPTH];
    bit                m_busy;
    int                m_idx;
    logic [DATA_W-1:0] m_pat;
    logic [DATA_W-1:0] e_da, e_db;
    bit                e_va, e_vb, e_pa, e_pb;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .clear      (clear),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en_a    (rd_en_a),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_valid_a (rd_valid_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .rd_valid_b (rd_valid_b),
`ifdef REGFILE_PARITY_EN
        .rd_perr_a  (rd_perr_a),
        .rd_perr_b  (rd_perr_b),
        .par_flip   (par_flip),
`endif
        .fill_req   (fill_req),
        .fill_data  (fill_data),
        .busy       (busy)
    );

`ifndef REGFILE_PARITY_EN
    assign rd_perr_a = 1'b0;
    assign rd_perr_b = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_bad[i] = 1'b0;
        end
        m_busy = 1'b0; m_idx = 0; m_pat = '0;
        e_da = '0; e_db = '0; e_va = 1'b0; e_vb = 1'b0; e_pa = 1'b0; e_pb = 1'b0;
    endtask

    task automatic idle_inputs();
        enable = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
        fill_req = 1'b0; fill_data = '0; par_flip = 1'b0;
    endtask

    // One clock: predict from current inputs, let the edge pass, compare every output.
    task automatic tick();
        bit wr_ok, ra, rb, hit_a, hit_b;
        wr_ok = enable && wr_en && !m_busy && !fill_req;
        ra    = enable && rd_en_a && !m_busy;
        rb    = enable && rd_en_b && !m_busy;
        hit_a = wr_ok && (wr_addr == rd_addr_a);
        hit_b = wr_ok && (wr_addr == rd_addr_b);
        if (ra) e_da = hit_a ? wr_data : m_mem[rd_addr_a];
        if (rb) e_db = hit_b ? wr_data : m_mem[rd_addr_b];
        e_va = ra; e_vb = rb;
        e_pa = ra && !hit_a && m_bad[rd_addr_a];
        e_pb = rb && !hit_b && m_bad[rd_addr_b];
        if (m_busy) begin
            m_mem[m_idx] = m_pat; m_bad[m_idx] = 1'b0;
            m_idx++;
            if (m_idx == DEPTH) m_busy = 1'b0;
        end else if (fill_req) begin
            m_busy = 1'b1; m_pat = fill_data; m_idx = 0;
        end else if (wr_ok) begin
            m_mem[wr_addr] = wr_data; m_bad[wr_addr] = par_flip;
        end
        @(posedge clk); #1;
        check("rd_data_a", rd_data_a, e_da);
        check("rd_data_b", rd_data_b, e_db);
        check("rd_valid_a", rd_valid_a, e_va);
        check("rd_valid_b", rd_valid_b, e_vb);
        check("busy", busy, m_busy);
`ifdef REGFILE_PARITY_EN
        check("rd_perr_a", rd_perr_a, e_pa);
        check("rd_perr_b", rd_perr_b, e_pb);
`endif
    endtask

    task automatic read_pair(input int a, input int b);
        idle_inputs();
        rd_en_a = 1'b1; rd_addr_a = ADDR_W'(a);
        rd_en_b = 1'b1; rd_addr_b = ADDR_W'(b);
        tick();
    endtask

    initial begin
        int cnt;
        idle_inputs();
        model_reset();
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_valid_a", rd_valid_a, 0);
        check("reset_data_b", rd_data_b, 0);
        clear = 1'b0;

        // Read after reset returns zero
        read_pair(3, 5);
        check("lit_reset_rd_a", rd_data_a, 32'h00);
        check("lit_reset_rd_b", rd_data_b, 32'h00);
        check("lit_reset_va", rd_valid_a, 1);
        check("lit_reset_vb", rd_valid_b, 1);

        // Write then read with one-cycle latency
        idle_inputs(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hA5;
        tick();
        read_pair(2, 0);
        check("lit_wr_rd", rd_data_a, 32'hA5);
        idle_inputs(); tick();
        check("lit_valid_pulse", rd_valid_a, 0);
        check("lit_data_hold", rd_data_a, 32'hA5);

        // Same-cycle write and dual read: bypass
        idle_inputs(); wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h3C;
        rd_en_a = 1'b1; rd_addr_a = 3'd6; rd_en_b = 1'b1; rd_addr_b = 3'd6;
        tick();
        check("lit_bypass_a", rd_data_a, 32'h3C);
        check("lit_bypass_b", rd_data_b, 32'h3C);

        // Fill sweep with a colliding write that must be dropped
        idle_inputs(); fill_req = 1'b1; fill_data = 8'h5A;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        tick();
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            cnt++;
            idle_inputs();
            if (cnt == 4) begin
                wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h11;
                fill_req = 1'b1; fill_data = 8'h77;
            end
            tick();
        end
        check("lit_fill_cycles", cnt, 8);
        for (int i = 0; i < DEPTH; i++) begin
            read_pair(i, DEPTH - 1 - i);
            check("lit_fill_val_a", rd_data_a, 32'h5A);
            check("lit_fill_val_b", rd_data_b, 32'h5A);
        end

        // Clear during the 4th fill cycle
        idle_inputs(); fill_req = 1'b1; fill_data = 8'hC3;
        tick();
        idle_inputs();
        repeat (3) tick();
        #2 clear = 1'b1;
        #1;
        check("lit_clear_busy", busy, 0);
        check("lit_clear_valid", rd_valid_a, 0);
        model_reset();
        #1 clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            read_pair(i, i);
            check("lit_clear_zero", rd_data_a, 32'h00);
        end

`ifdef REGFILE_PARITY_EN
        idle_inputs(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h96; par_flip = 1'b1;
        tick();
        read_pair(1, 2);
        check("lit_perr_flip", rd_perr_a, 1);
        check("lit_perr_other", rd_perr_b, 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            enable    = ($urandom_range(0, 7) != 0);
            wr_en     = $urandom_range(0, 1);
            wr_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_data   = DATA_W'($urandom);
            rd_en_a   = $urandom_range(0, 1);
            rd_addr_a = ADDR_W'($urandom_range(0, DEPTH - 1));
            rd_en_b   = $urandom_range(0, 1);
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : ADDR_W'($urandom_range(0, DEPTH - 1));
            fill_req  = ($urandom_range(0, 39) == 0);
            fill_data = DATA_W'($urandom);
            par_flip  = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the compute tile's 8x8 register file: DEPTH x DATA_W storage, one write port and two independent registered read ports.
- Adds write-to-read bypass, per-port read-valid strobes and a multi-cycle fill sequencer that loads every entry with a given pattern.
- Sits in the compute tile between the operand bus and the ALU. Two operands are read per cycle; results are written back through the write port.

Parameters:
- DATA_W, 8, entry width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden

Ports:
- clk  in  1  clock, rising edge
- clear  in  1  asynchronous active-high reset
- enable  in  1  global block enable; when 0, no state changes except the fill sequencer
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en_a  in  1  port A read strobe
- rd_addr_a  in  ADDR_W  port A address
- rd_data_a  out  DATA_W  port A registered data
- rd_valid_a  out  1  port A data valid (1-cycle pulse)
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: same as port A
- fill_req  in  1  start fill sweep (single-cycle pulse)
- fill_data  in  DATA_W  pattern for the sweep; sampled on the fill_req cycle
- busy  out  1  fill sweep in progress

Behaviour:
- Reset (clear=1, asynchronous): all entries are 0, rd_data_a/b=0, rd_valid_a/b=0, busy=0, FSM=IDLE, fill counter=0.
- Write: when enable&wr_en&!busy, mem[wr_addr]<=wr_data on the clk edge.
- Read: when enable&rd_en_x&!busy, rd_data_x<=mem[rd_addr_x] on the clk edge and rd_valid_x<=1. Otherwise rd_valid_x<=0 and rd_data_x holds its value. Latency is 1 cycle.
- Bypass: if a write and a read to the same address are accepted in the same cycle, the read returns wr_data, never the old value. Applies to each port independently.
- Both ports reading the same address is legal; both return the same data.
- FSM:
  - IDLE: if fill_req, latch fill_data, counter=0, busy=1, go to FILL. fill_req is honoured even when enable=0.
  - FILL: each cycle mem[counter]<=pattern and counter++. At counter==DEPTH-1, write the last entry, busy<=0 and return to IDLE. The sweep takes exactly DEPTH cycles.
  - fill_req during FILL is ignored (no restart).
- During busy, wr_en and rd_en are ignored (no write, rd_valid=0). Upstream stalls on busy.
- A fill_req in the same cycle as wr_en: the fill wins and the write is dropped; busy rises in the next cycle.
- clear asserted mid-fill: immediate return to the reset state; partial fill contents are discarded (all zero).
- Address wrap: the counter is ADDR_W+1 bits wide, so there is no aliasing at DEPTH-1.

Optional Feature:
- REGFILE_PARITY_EN defined:
  - each entry stores an extra even-parity bit computed on write and on fill.
  - Outputs rd_perr_a/rd_perr_b (1 bit each, reset 0) assert alongside rd_valid_x when the stored parity mismatches. A bypassed read reports perr=0.
  - A test-only input par_flip inverts the stored parity bit on the next accepted write.
- Not defined: no parity storage, no perr ports, no par_flip port.

Decomposition:
- Shared package regfile_pkg: fill FSM state enum (IDLE, FILL) and a parity function.
- One natural sub-module, regfile_rd_port: the registered read with bypass compare. It is instantiated twice, for ports A and B.
- Storage, the write decoder and the fill FSM stay in the top.

Test Plan:
- clear pulse, then read A=3, B=5 -> next cycle rd_data_a=rd_data_b=0x00, both rd_valid=1.
- Write 0xA5 to addr 2, then one cycle later read A=2 -> rd_data_a=0xA5 one cycle after the read strobe, rd_valid_a one-cycle pulse.
- Same cycle: write 0x3C to addr 6, read A=6, B=6 -> both return 0x3C (bypass).
- fill_req with fill_data=0x5A (DEPTH=8) -> busy high for exactly 8 cycles; a wr_en mid-fill is ignored; afterwards every address reads 0x5A.
- Fill in progress, clear at the 4th fill cycle -> busy=0 immediately; all entries read 0x00.
- REGFILE_PARITY_EN with par_flip on a write to addr 1 -> read addr 1 gives rd_perr_a=1; other addresses give 0.
